// File: rtl/fighter_pkg.sv
// Shared definitions for the fighter animation controller.
//   anim_state_t : action FSM encoding (also driven onto state_out)
//   *_FRAMES     : number of animation frames per action
//   *_BASE       : first frame of each action in the sprite sheet; the
//                  sheet stores IDLE, WALK, PUNCH, KICK, HIT back to back
//   SPR_*_DEF    : default sprite cell size in pixels
package fighter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WALK  = 3'd1,
    PUNCH = 3'd2,
    KICK  = 3'd3,
    HIT   = 3'd4
  } anim_state_t;

  localparam int SPR_W_DEF = 60;
  localparam int SPR_H_DEF = 90;

  localparam int IDLE_FRAMES  = 4;
  localparam int WALK_FRAMES  = 4;
  localparam int PUNCH_FRAMES = 3;
  localparam int KICK_FRAMES  = 4;
  localparam int HIT_FRAMES   = 2;

  localparam int IDLE_BASE  = 0;
  localparam int WALK_BASE  = IDLE_BASE  + IDLE_FRAMES;
  localparam int PUNCH_BASE = WALK_BASE  + WALK_FRAMES;
  localparam int KICK_BASE  = PUNCH_BASE + PUNCH_FRAMES;
  localparam int HIT_BASE   = KICK_BASE  + KICK_FRAMES;

  function automatic logic [2:0] frame_count(input anim_state_t s);
    case (s)
      IDLE:    return 3'(IDLE_FRAMES);
      WALK:    return 3'(WALK_FRAMES);
      PUNCH:   return 3'(PUNCH_FRAMES);
      KICK:    return 3'(KICK_FRAMES);
      HIT:     return 3'(HIT_FRAMES);
      default: return 3'(IDLE_FRAMES);
    endcase
  endfunction

  function automatic logic [4:0] sheet_base(input anim_state_t s);
    case (s)
      IDLE:    return 5'(IDLE_BASE);
      WALK:    return 5'(WALK_BASE);
      PUNCH:   return 5'(PUNCH_BASE);
      KICK:    return 5'(KICK_BASE);
      HIT:     return 5'(HIT_BASE);
      default: return 5'(IDLE_BASE);
    endcase
  endfunction

endpackage

// File: rtl/fighter_anim_ctrl_sprite_addr_gen.sv
// sprite_addr_gen: one-cycle DrawX/DrawY -> sprite ROM address pipeline.
//   vga_clk, reset      : pixel clock, asynchronous active-high reset
//   draw_x, draw_y      : current beam position
//   sprite_x            : sprite left edge (top edge is GROUND_Y)
//   frame_base          : ROM address of the current frame's first pixel
//   mirror              : flip columns horizontally (FIGHTER_MIRROR_EN only)
//   rom_address         : registered ROM address; holds frame_base outside
//                         the sprite box
//   in_sprite           : registered, aligned with rom_address
// Build option: define FIGHTER_MIRROR_EN to read columns right-to-left
// when mirror=1; otherwise mirror is ignored.
module sprite_addr_gen
  import fighter_pkg::*;
#(
  parameter int SPR_W    = SPR_W_DEF,
  parameter int SPR_H    = SPR_H_DEF,
  parameter int ADDR_W   = 17,
  parameter int GROUND_Y = 300
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        sprite_x,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              mirror,
  output logic [ADDR_W-1:0] rom_address,
  output logic              in_sprite
);

  localparam logic signed [10:0] SPR_W_S    = 11'(SPR_W);
  localparam logic signed [10:0] SPR_H_S    = 11'(SPR_H);
  localparam logic signed [10:0] GROUND_Y_S = 11'(GROUND_Y);

  logic signed [10:0] dx_p0, dy_p0;
  logic               hit_p0;
  logic [ADDR_W-1:0]  col_p0, row_p0, addr_p0;
  logic [ADDR_W-1:0]  rom_address_p1;
  logic               vld_p1;

  // ---- stage p0: offsets into the sprite box (one extra bit for sign)
  assign dx_p0  = $signed({1'b0, draw_x}) - $signed({1'b0, sprite_x});
  assign dy_p0  = $signed({1'b0, draw_y}) - GROUND_Y_S;
  assign hit_p0 = (dx_p0 >= 11'sd0) && (dx_p0 < SPR_W_S) &&
                  (dy_p0 >= 11'sd0) && (dy_p0 < SPR_H_S);

`ifdef FIGHTER_MIRROR_EN
  always_comb begin
    col_p0 = ADDR_W'($unsigned(dx_p0));
    if (mirror) col_p0 = ADDR_W'(SPR_W - 1) - ADDR_W'($unsigned(dx_p0));
  end
`else
  logic mirror_unused;
  assign mirror_unused = mirror;
  assign col_p0 = ADDR_W'($unsigned(dx_p0));
`endif

  // Row/column terms are only meaningful when hit_p0 is set.
  assign row_p0  = ADDR_W'($unsigned(dy_p0)) * ADDR_W'(SPR_W);
  assign addr_p0 = frame_base + row_p0 + col_p0;

  // ---- stage p1: registered address and in-box flag
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address_p1 <= '0;
      vld_p1         <= 1'b0;
    end else begin
      vld_p1         <= hit_p0;
      rom_address_p1 <= hit_p0 ? addr_p0 : frame_base;
    end
  end

  assign rom_address = rom_address_p1;
  assign in_sprite   = vld_p1;

endmodule

// File: rtl/fighter_anim_ctrl.sv
// fighter_anim_ctrl: animation sequencer and sprite address generator for
// one fighter.
//   vga_clk, reset        : pixel clock, asynchronous active-high reset
//   frame_tick            : one-cycle pulse per video frame (vblank)
//   req_left/req_right    : walk requests (held)
//   req_punch/req_kick    : attack requests (level)
//   hit_in                : one-cycle pulse, fighter struck
//   DrawX, DrawY          : current beam position
//   rom_address,in_sprite : registered sprite ROM address / in-box flag
//   sprite_x, facing_left : position and facing
//   state_out, attacking  : current action, high in PUNCH/KICK
// Build option: FIGHTER_MIRROR_EN flips the sprite horizontally when
// facing_left=1 (handled inside sprite_addr_gen).
// ADDR_W must hold (total frames x SPR_W x SPR_H).
module fighter_anim_ctrl
  import fighter_pkg::*;
#(
  parameter int SPR_W           = SPR_W_DEF,
  parameter int SPR_H           = SPR_H_DEF,
  parameter int ADDR_W          = 17,
  parameter int TICKS_PER_FRAME = 6,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 580,
  parameter int X_START         = 100,
  parameter int GROUND_Y        = 300,
  parameter int STEP            = 2
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              req_left,
  input  logic              req_right,
  input  logic              req_punch,
  input  logic              req_kick,
  input  logic              hit_in,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_address,
  output logic              in_sprite,
  output logic [9:0]        sprite_x,
  output logic              facing_left,
  output logic [2:0]        state_out,
  output logic              attacking
);

  localparam int TC_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic signed [11:0] STEP_S  = 12'(STEP);
  localparam logic signed [11:0] X_MIN_S = 12'(X_MIN);
  localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);

  // Move one step and saturate at the screen bounds (no wrap).
  function automatic logic [9:0] step_x(input logic [9:0] x, input logic left);
    logic signed [11:0] nx;
    nx = left ? ($signed({2'b00, x}) - STEP_S) : ($signed({2'b00, x}) + STEP_S);
    if (nx < X_MIN_S)      return 10'(X_MIN);
    else if (nx > X_MAX_S) return 10'(X_MAX);
    else                   return 10'(nx);
  endfunction

  function automatic logic [ADDR_W-1:0] calc_base(input anim_state_t s,
                                                  input logic [2:0]  f);
    return ADDR_W'(sheet_base(s) + 5'(f)) * ADDR_W'(SPR_W * SPR_H);
  endfunction

  anim_state_t       state_q, state_d, want;
  logic [TC_W-1:0]   tick_q, tick_d;
  logic [2:0]        frame_q, frame_d;
  logic [9:0]        x_q, x_d;
  logic              face_q, face_d;
  logic              hit_pend_q, hit_pend_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              walk_req, last_tick, last_frame, busy, done, enter;

  assign walk_req   = req_left ^ req_right;
  assign last_tick  = (tick_q == TC_W'(TICKS_PER_FRAME - 1));
  assign last_frame = (frame_q == frame_count(state_q) - 3'd1);
  assign busy       = (state_q == PUNCH) || (state_q == KICK) || (state_q == HIT);
  assign done       = last_tick && last_frame;

  always_comb begin
    if (req_punch)     want = PUNCH;
    else if (req_kick) want = KICK;
    else if (walk_req) want = WALK;
    else               want = IDLE;
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    frame_d    = frame_q;
    x_d        = x_q;
    face_d     = face_q;
    hit_pend_d = hit_pend_q | hit_in;
    base_d     = base_q;
    enter      = 1'b0;
    if (frame_tick) begin
      // A hit arriving on the tick cycle itself is consumed immediately.
      hit_pend_d = 1'b0;
      if (hit_pend_q || hit_in) begin
        state_d = HIT;
        enter   = 1'b1;
      end else if (busy && !done) begin
        state_d = state_q;
      end else if (busy || (want != state_q)) begin
        // Finishing an attack goes through the normal priority pick, so a
        // still-held request re-enters that action from frame 0.
        state_d = want;
        enter   = 1'b1;
      end

      if (enter) begin
        tick_d  = '0;
        frame_d = '0;
      end else if (last_tick) begin
        tick_d  = '0;
        frame_d = last_frame ? 3'd0 : frame_q + 3'd1;
      end else begin
        tick_d  = tick_q + TC_W'(1);
      end

      if (state_d == WALK) begin
        face_d = req_left;
        x_d    = step_x(x_q, req_left);
      end
      base_d = calc_base(state_d, frame_d);
    end
  end

  // ---- control registers, updated only at vblank ticks
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      frame_q    <= '0;
      x_q        <= 10'(X_START);
      face_q     <= 1'b0;
      hit_pend_q <= 1'b0;
      base_q     <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      frame_q    <= frame_d;
      x_q        <= x_d;
      face_q     <= face_d;
      hit_pend_q <= hit_pend_d;
      base_q     <= base_d;
    end
  end

  sprite_addr_gen #(
    .SPR_W    (SPR_W),
    .SPR_H    (SPR_H),
    .ADDR_W   (ADDR_W),
    .GROUND_Y (GROUND_Y)
  ) u_addr (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .draw_x      (DrawX),
    .draw_y      (DrawY),
    .sprite_x    (x_q),
    .frame_base  (base_q),
    .mirror      (face_q),
    .rom_address (rom_address),
    .in_sprite   (in_sprite)
  );

  assign sprite_x    = x_q;
  assign facing_left = face_q;
  assign state_out   = state_q;
  assign attacking   = (state_q == PUNCH) || (state_q == KICK);

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
module tb_fighter_anim_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset, frame_tick, req_left, req_right, req_punch, req_kick, hit_in;
  logic [9:0]  DrawX, DrawY;
  logic [16:0] rom_address;
  logic        in_sprite;
  logic [9:0]  sprite_x;
  logic        facing_left;
  logic [2:0]  state_out;
  logic        attacking;

  fighter_anim_ctrl dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .req_left    (req_left),
    .req_right   (req_right),
    .req_punch   (req_punch),
    .req_kick    (req_kick),
    .hit_in      (hit_in),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .rom_address (rom_address),
    .in_sprite   (in_sprite),
    .sprite_x    (sprite_x),
    .facing_left (facing_left),
    .state_out   (state_out),
    .attacking   (attacking)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    string       tag;
    logic        in_s;
    logic [16:0] addr;
  } pix_exp_t;

  pix_exp_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic exp_face = 1'b0;
  logic [16:0] mir_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected ROM address: sheet frame number, offsets inside the box.
  function automatic logic [16:0] addr_of(input int frame_no, input int dx, input int dy);
    int col;
    col = dx;
`ifdef FIGHTER_MIRROR_EN
    if (exp_face) col = 59 - dx;
`endif
    return 17'(frame_no * 5400 + dy * 60 + col);
  endfunction

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge vga_clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic pix(input string tag, input int x, input int y,
                     input logic ein, input logic [16:0] ea);
    pix_exp_t e;
    DrawX = 10'(x);
    DrawY = 10'(y);
    sb_q.push_back('{tag, ein, ea});
    @(posedge vga_clk); #1;
    e = sb_q.pop_front();
    check({e.tag, "_in"},   in_sprite,   e.in_s);
    check({e.tag, "_addr"}, rom_address, e.addr);
  endtask

  task automatic check_core(input string tag, input int st, input int x,
                            input logic face, input logic att);
    check({tag, "_state"}, state_out,   st);
    check({tag, "_x"},     sprite_x,    x);
    check({tag, "_face"},  facing_left, face);
    check({tag, "_att"},   attacking,   att);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_tick = 0; req_left = 0; req_right = 0;
    req_punch = 0; req_kick = 0; hit_in = 0; DrawX = 0; DrawY = 0;
    repeat (2) @(posedge vga_clk);
    #1;
    check_core("rst", 0, 100, 0, 0);
    check("rst_rom", rom_address, 0);
    check("rst_in",  in_sprite,   0);
    reset = 1'b0;

    // IDLE frame 0 at x=100: box corners and just-outside pixels
    pix("p_tl", 100, 300, 1, 17'd0);
    pix("p_br", 159, 389, 1, 17'd5399);
    pix("p_xr", 160, 389, 0, 17'd0);
    pix("p_xl",  99, 300, 0, 17'd0);
    pix("p_ya", 100, 299, 0, 17'd0);
    pix("p_yb", 100, 390, 0, 17'd0);

    // walk right 10 ticks
    req_right = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_core($sformatf("wr%0d", k), 1, 100 + 2 * (k + 1), 0, 0);
      pix($sformatf("wrp%0d", k), 100 + 2 * (k + 1) + 10, 305, 1,
          addr_of(4 + (k / 6) % 4, 10, 5));
    end
    req_right = 0;
    tick();
    check_core("wr_stop", 0, 120, 0, 0);
    pix("idle_base", 120, 300, 1, 17'd0);

    req_left = 1; req_right = 1;
    tick();
    check_core("both", 0, 120, 0, 0);
    req_left = 0; req_right = 0;

    // right bound saturation
    req_right = 1;
    for (int i = 0; i < 233; i++) tick();
    check_core("xmax", 1, 580, 0, 0);
    tick();
    check_core("xmax_hold", 1, 580, 0, 0);
    req_right = 0;

    // turn and walk to the left bound
    req_left = 1;
    tick();
    exp_face = 1'b1;
    check_core("turn", 1, 578, 1, 0);
    for (int i = 0; i < 292; i++) tick();
    check_core("xmin", 1, 0, 1, 0);
    req_left = 0;
    tick();
    check_core("left_idle", 0, 0, 1, 0);

`ifdef FIGHTER_MIRROR_EN
    mir_exp = 17'd59;
`else
    mir_exp = 17'd0;
`endif
    pix("mir0", 0, 300, 1, mir_exp);
    pix("mir59", 59, 300, 1, addr_of(0, 59, 0));

    // punch for 18 ticks; a kick held mid-punch is ignored
    req_punch = 1;
    tick();
    check_core("pun0", 2, 0, 1, 1);
    req_punch = 0;
    for (int t = 1; t < 18; t++) begin
      req_kick = (t >= 3 && t <= 8);
      tick();
      check_core($sformatf("pun%0d", t), 2, 0, 1, 1);
      if (t == 6)  pix("pun_f1", 10, 305, 1, addr_of(9, 10, 5));
      if (t == 12) pix("pun_f2", 10, 305, 1, addr_of(10, 10, 5));
    end
    req_kick = 0;
    tick();
    check_core("pun_end", 0, 0, 1, 0);

    // kick, struck between ticks
    req_kick = 1;
    tick();
    check_core("kick0", 3, 0, 1, 1);
    req_kick = 0;
    pix("kick_base", 0, 300, 1, addr_of(11, 0, 0));
    repeat (3) tick();
    check_core("kick3", 3, 0, 1, 1);
    hit_in = 1;
    @(posedge vga_clk); #1;
    hit_in = 0;
    repeat (2) @(posedge vga_clk);
    #1;
    check_core("hit_wait", 3, 0, 1, 1);
    tick();
    check_core("hit0", 4, 0, 1, 0);
    pix("hit_base", 0, 300, 1, addr_of(15, 0, 0));
    for (int t = 1; t < 12; t++) begin
      tick();
      check_core($sformatf("hit%0d", t), 4, 0, 1, 0);
      if (t == 6) pix("hit_f1", 3, 307, 1, addr_of(16, 3, 7));
    end
    tick();
    check_core("hit_end", 0, 0, 1, 0);

    // hit while in HIT restarts it at frame 0
    hit_in = 1;
    tick();
    hit_in = 0;
    check_core("rehit0", 4, 0, 1, 0);
    repeat (7) tick();
    pix("rehit_f1", 0, 300, 1, addr_of(16, 0, 0));
    hit_in = 1;
    @(posedge vga_clk); #1;
    hit_in = 0;
    tick();
    check_core("rehit_restart", 4, 0, 1, 0);
    pix("rehit_f0", 0, 300, 1, addr_of(15, 0, 0));
    repeat (11) tick();
    check_core("rehit_last", 4, 0, 1, 0);
    tick();
    check_core("rehit_end", 0, 0, 1, 0);

    // reset in the middle of a walk
    req_right = 1;
    tick();
    exp_face = 1'b0;
    for (int i = 0; i < 149; i++) tick();
    check_core("w300", 1, 300, 0, 0);
    DrawX = 10'd310; DrawY = 10'd320;
    @(posedge vga_clk); #1;
    check("pre_rst_in", in_sprite, 1);
    reset = 1'b1;
    @(posedge vga_clk); #1;
    check_core("rst2", 0, 100, 0, 0);
    check("rst2_rom", rom_address, 0);
    check("rst2_in",  in_sprite,   0);
    reset = 1'b0;
    req_right = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
